pulse_window_capture: RTL and testbench
=======================================

PULSE_WINDOW_CAPTURE -- requirements
Module: pulse_window_capture

Interface
REQ-001 Parameter ADC_WIDTH, default 14, SHALL set the signed sample width.
REQ-002 Parameter AXIS_TDATA_WIDTH, default 32, SHALL set the adc_dat_a and m_axis_tdata width.
REQ-003 Parameter MIN_LEN, default 2, SHALL set the minimum accepted window length in cycles.
REQ-004 Parameter MAX_LEN, default 1024, SHALL set the maximum accepted window length in cycles (MAX_LEN < 65535).
REQ-005 Parameter FIFO_DEPTH, default 4, SHALL set the event FIFO depth (power of 2).
REQ-006 adc_clk input 1: the clock; all logic SHALL be on its rising edge.
REQ-007 rst input 1: the reset, synchronous, active-low.
REQ-008 adc_dat_a input AXIS_TDATA_WIDTH: raw ADC word; bits [ADC_WIDTH-1:0] are the signed sample.
REQ-009 vgl input 1: registered low-threshold flag (sample >= low level); it lags adc_dat_a by one cycle.
REQ-010 vgh input 1: registered high-threshold flag (sample >= high level); it is aligned with vgl.
REQ-011 enable input 1: arms capture; it is sampled only in IDLE.
REQ-012 m_axis_tdata output AXIS_TDATA_WIDTH: event word {2'b00, len[15:0], peak[13:0]}.
REQ-013 m_axis_tvalid output 1, m_axis_tready input 1: AXI4-Stream handshake.
REQ-014 event_cnt output 32: accepted events (wraps).
REQ-015 drop_cnt output 16: events lost to a full FIFO (saturates at 0xFFFF).
REQ-016 reject_cnt output 16: windows rejected for length or vgh (saturates at 0xFFFF).

Function
REQ-017 The sample SHALL be delayed one register stage so that the sample and vgl/vgh refer to the same ADC cycle.
REQ-018 The state machine SHALL have three states, IDLE, ACTIVE and REJECT, with transitions as follows:
- IDLE -> ACTIVE when enable=1 and vgl=1.
- ACTIVE -> IDLE when vgl=0 (window end).
- ACTIVE -> REJECT when len would exceed MAX_LEN.
- REJECT -> IDLE when vgl=0.
REQ-019 On entry to ACTIVE: len SHALL load 1, peak SHALL load the aligned sample, and hi_seen SHALL load vgh.
REQ-020 Each further ACTIVE cycle with vgl=1: len SHALL increment, peak SHALL update to the sample if the sample > peak (signed compare), and hi_seen |= vgh.
REQ-021 At window end the event SHALL be accepted iff MIN_LEN <= len <= MAX_LEN and hi_seen=0; otherwise reject_cnt SHALL increment.
REQ-022 On a MAX_LEN overflow, reject_cnt SHALL increment once on entry to REJECT, and no event SHALL be generated for that window.
REQ-023 An accepted event SHALL be pushed into the FIFO on the cycle after the window-end cycle.
- If the push succeeds, event_cnt SHALL increment.
- If the push fails, drop_cnt SHALL increment.
REQ-024 The push SHALL succeed if FIFO count < FIFO_DEPTH, or if a pop (tvalid & tready) occurs in the same cycle.
REQ-025 m_axis_tvalid SHALL equal (FIFO count != 0).
- tdata SHALL be the oldest entry, held stable until tready is seen.
- A pop SHALL occur on tvalid & tready.
REQ-026 A simultaneous push and pop SHALL leave the count unchanged, with the order preserved.
REQ-027 enable=0 during ACTIVE or REJECT SHALL NOT abort the window in progress.
REQ-028 Latency SHALL be fixed: tvalid rises 2 cycles after the first vgl=0 cycle when the FIFO was empty.
REQ-029 The len field SHALL be zero-extended to 16 bits; peak SHALL be the raw 14-bit two's complement value.

Reset
REQ-030 On adc_clk with rst=0, the block SHALL enter IDLE and clear len, peak, hi_seen, the FIFO pointers and count, event_cnt, drop_cnt and reject_cnt.
REQ-031 During reset, m_axis_tvalid SHALL be 0, and m_axis_tdata SHALL be 0.
REQ-032 Reset asserted mid-window or with the FIFO non-empty SHALL discard all pending events, with no counter increment.
REQ-033 The first cycle after reset release SHALL behave as IDLE, including for a vgl already high.

Verification
REQ-034 Pulse test: enable=1, vgl high 5 cycles, samples 100, 300, 800, 500, 200, vgh=0, tready=1 -> one beat with len=5, peak=800, tdata=0x0001_4320, event_cnt=1.
REQ-035 Negative-peak test: vgl high 3 cycles, samples -50, -10, -30, MIN_LEN=2 -> peak=-10 (0x3FF6), len=3.
REQ-036 Rejection test: a 1-cycle pulse -> reject_cnt=1 and no tvalid; a window with vgh=1 on one cycle -> reject_cnt=2; a 1100-cycle window -> REJECT entered at cycle 1025, reject_cnt=3, and the state returns to IDLE after vgl falls.
REQ-037 FIFO-full test: tready=0, 6 valid pulses -> count=4, event_cnt=4, drop_cnt=2; then tready=1 -> 4 beats in arrival order.
REQ-038 Simultaneous push/pop test: FIFO full with a push and tready=1 in the same cycle -> push accepted, drop_cnt unchanged, count stays 4.
REQ-039 Mid-window reset test: rst=0 at pulse cycle 3 -> no event emitted, all counters 0, tvalid=0; the next pulse is captured normally.

Source files
------------

// File: rtl/pulse_window_capture.sv
// -----------------------------------------------------------------------------
// pulse_window_capture
//
// Captures pulse windows from an ADC stream. A window is the run of cycles where
// the registered low-threshold flag (vgl) is high. For each window the block
// tracks its length, its signed peak sample, and whether the high-threshold
// flag (vgh) was ever seen. Windows of acceptable length that never crossed the
// high threshold become event words. These words are queued in a small FIFO and
// streamed out over AXI4-Stream.
//
// Ports
//   adc_clk        : clock, all logic on the rising edge
//   rst            : synchronous reset, active low
//   adc_dat_a      : raw ADC word, [ADC_WIDTH-1:0] is the signed sample
//   vgl / vgh      : registered threshold flags, one cycle behind adc_dat_a
//   enable         : arms capture, only looked at while idle
//   m_axis_tdata   : event word {2'b00, len[15:0], peak[ADC_WIDTH-1:0]}
//   m_axis_tvalid  : FIFO holds at least one event
//   m_axis_tready  : downstream accepts the current word
//   event_cnt      : events written to the FIFO (wraps)
//   drop_cnt       : events lost to a full FIFO (saturating)
//   reject_cnt     : windows rejected for length or vgh (saturating)
// -----------------------------------------------------------------------------
module pulse_window_capture #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MIN_LEN          = 2,
  parameter int MAX_LEN          = 1024,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        adc_clk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] adc_dat_a,
  input  logic                        vgl,
  input  logic                        vgh,
  input  logic                        enable,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [31:0]                 event_cnt,
  output logic [15:0]                 drop_cnt,
  output logic [15:0]                 reject_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [15:0]      MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [15:0]      MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [CNT_W-1:0] DEPTH_W   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_REJECT = 2'd2
  } state_t;

  // Saturating 16-bit increment used by the drop and reject counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hFFFF)) begin
      return v + 16'd1;
    end else begin
      return v;
    end
  endfunction

  // Packs length and peak into the outgoing event word; unused top bits stay 0.
  function automatic logic [AXIS_TDATA_WIDTH-1:0] pack_event(
    input logic [15:0]          len,
    input logic [ADC_WIDTH-1:0] peak
  );
    logic [AXIS_TDATA_WIDTH-1:0] w;
    w                  = '0;
    w[ADC_WIDTH-1:0]   = peak;
    w[ADC_WIDTH +: 16] = len;
    return w;
  endfunction

  // Window tracking state
  state_t                       state_q, state_d;
  logic signed [ADC_WIDTH-1:0]  sample_q, sample_d;
  logic [15:0]                  len_q, len_d;
  logic signed [ADC_WIDTH-1:0]  peak_q, peak_d;
  logic                         hi_seen_q, hi_seen_d;
  logic                         push_q, push_d;
  logic [AXIS_TDATA_WIDTH-1:0]  event_word_q, event_word_d;

  // Event FIFO
  logic [AXIS_TDATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [AXIS_TDATA_WIDTH-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         m_axis_tvalid_q, m_axis_tvalid_d;
  logic [AXIS_TDATA_WIDTH-1:0]  m_axis_tdata_q, m_axis_tdata_d;

  // Counters
  logic [31:0]                  event_cnt_q, event_cnt_d;
  logic [15:0]                  drop_cnt_q, drop_cnt_d;
  logic [15:0]                  reject_cnt_q, reject_cnt_d;

  logic                         reject_inc_s;
  logic                         window_ok_s;
  logic                         pop_s;
  logic                         push_ok_s;
  logic                         unused_upper_s;

  // Only the low ADC_WIDTH bits of the raw word carry the sample.
  assign unused_upper_s = &{1'b0, adc_dat_a[AXIS_TDATA_WIDTH-1:ADC_WIDTH]};

  // A finished window is kept only if its length is in range and vgh never fired.
  assign window_ok_s = (len_q >= MIN_LEN_W) && (len_q <= MAX_LEN_W) && !hi_seen_q;

  // Window state machine: next state, length, peak and event word.
  always_comb begin
    sample_d     = adc_dat_a[ADC_WIDTH-1:0];
    state_d      = state_q;
    len_d        = len_q;
    peak_d       = peak_q;
    hi_seen_d    = hi_seen_q;
    push_d       = 1'b0;
    event_word_d = event_word_q;
    reject_inc_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && vgl) begin
          state_d   = ST_ACTIVE;
          len_d     = 16'd1;
          peak_d    = sample_q;
          hi_seen_d = vgh;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACTIVE: begin
        if (vgl) begin
          // One more cycle would push the length past MAX_LEN: give up on this window.
          if (len_q >= MAX_LEN_W) begin
            state_d      = ST_REJECT;
            reject_inc_s = 1'b1;
          end else begin
            len_d     = len_q + 16'd1;
            hi_seen_d = hi_seen_q | vgh;
            if (sample_q > peak_q) begin
              peak_d = sample_q;
            end else begin
              peak_d = peak_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
          if (window_ok_s) begin
            push_d       = 1'b1;
            event_word_d = pack_event(len_q, peak_q);
          end else begin
            reject_inc_s = 1'b1;
          end
        end
      end

      ST_REJECT: begin
        if (!vgl) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REJECT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: a pending event gets in when there is room or a pop frees a slot.
  always_comb begin
    pop_s     = m_axis_tvalid_q & m_axis_tready;
    push_ok_s = push_q & ((count_q < DEPTH_W) | pop_s);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    // When full, wr_ptr equals rd_ptr, so a simultaneous push reuses the popped slot,
    // which becomes the youngest entry once rd_ptr advances.
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = event_word_q;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Outputs are registered from the post-update FIFO state.
    m_axis_tvalid_d = (count_d != '0);
    if (count_d != '0) begin
      m_axis_tdata_d = mem_d[rd_ptr_d];
    end else begin
      m_axis_tdata_d = '0;
    end

    if (push_ok_s) begin
      event_cnt_d = event_cnt_q + 32'd1;
    end else begin
      event_cnt_d = event_cnt_q;
    end
    drop_cnt_d   = sat_inc16(drop_cnt_q, push_q & ~push_ok_s);
    reject_cnt_d = sat_inc16(reject_cnt_q, reject_inc_s);
  end

  // All state registers; synchronous active-low reset discards everything pending.
  always_ff @(posedge adc_clk) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      sample_q        <= '0;
      len_q           <= 16'd0;
      peak_q          <= '0;
      hi_seen_q       <= 1'b0;
      push_q          <= 1'b0;
      event_word_q    <= '0;
      mem_q           <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      m_axis_tvalid_q <= 1'b0;
      m_axis_tdata_q  <= '0;
      event_cnt_q     <= 32'd0;
      drop_cnt_q      <= 16'd0;
      reject_cnt_q    <= 16'd0;
    end else begin
      state_q         <= state_d;
      sample_q        <= sample_d;
      len_q           <= len_d;
      peak_q          <= peak_d;
      hi_seen_q       <= hi_seen_d;
      push_q          <= push_d;
      event_word_q    <= event_word_d;
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      m_axis_tvalid_q <= m_axis_tvalid_d;
      m_axis_tdata_q  <= m_axis_tdata_d;
      event_cnt_q     <= event_cnt_d;
      drop_cnt_q      <= drop_cnt_d;
      reject_cnt_q    <= reject_cnt_d;
    end
  end

  assign m_axis_tvalid = m_axis_tvalid_q;
  assign m_axis_tdata  = m_axis_tdata_q;
  assign event_cnt     = event_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign reject_cnt    = reject_cnt_q;

endmodule

// File: tb/tb_pulse_window_capture.sv
// -----------------------------------------------------------------------------
// tb_pulse_window_capture
//
// Directed stimulus with a window-level reference model. The model collects the
// samples of each window and computes length and peak from the collected list.
// It keeps the event FIFO as a queue. Every cycle, the DUT outputs are compared
// against the model. Hand-computed literals at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_pulse_window_capture;

  localparam int AW      = 14;
  localparam int W       = 32;
  localparam int MIN_LEN = 2;
  localparam int MAX_LEN = 1024;
  localparam int DEPTH   = 4;

  logic          adc_clk = 1'b0;
  logic          rst     = 1'b0;
  logic [W-1:0]  adc_dat_a = '0;
  logic          vgl = 1'b0, vgh = 1'b0, enable = 1'b0, tready = 1'b0;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic [31:0]   event_cnt;
  logic [15:0]   drop_cnt, reject_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // flags belonging to the sample driven in the previous cycle
  logic pgl = 1'b0, pgh = 1'b0;

  always #5 adc_clk = ~adc_clk;

  pulse_window_capture #(
    .ADC_WIDTH(AW), .AXIS_TDATA_WIDTH(W), .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN), .FIFO_DEPTH(DEPTH)
  ) dut (
    .adc_clk(adc_clk), .rst(rst), .adc_dat_a(adc_dat_a),
    .vgl(vgl), .vgh(vgh), .enable(enable),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(tready),
    .event_cnt(event_cnt), .drop_cnt(drop_cnt), .reject_cnt(reject_cnt)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ev_word(input int len, input int pk);
    logic [15:0] l;
    logic [13:0] p;
    l = 16'(len);
    p = 14'(pk);
    return {2'b00, l, p};
  endfunction

  // ---------------- reference model ----------------
  bit           m_ok = 1'b0;
  logic [W-1:0] m_last_adc;
  bit           m_in_win, m_ovf, m_hi, m_pend;
  int           m_win[$];
  logic [31:0]  m_pend_word;
  logic [31:0]  m_fifo[$];
  logic [31:0]  m_ev;
  int           m_drop, m_rej;
  logic [31:0]  beats[$];

  always @(negedge adc_clk) begin : model
    logic signed [AW-1:0] s14;
    int s, len, pk;
    logic [31:0] exp_data;
    if (m_ok) begin
      exp_data = (m_fifo.size() != 0) ? m_fifo[0] : 32'h0;
      check32("tvalid", {31'd0, m_axis_tvalid}, {31'd0, (m_fifo.size() != 0)});
      check32("tdata", m_axis_tdata, exp_data);
      check32("event_cnt", event_cnt, m_ev);
      check32("drop_cnt", {16'd0, drop_cnt}, 32'(m_drop));
      check32("reject_cnt", {16'd0, reject_cnt}, 32'(m_rej));
      if (m_axis_tvalid === 1'b1 && tready) beats.push_back(m_axis_tdata);
    end
    // advance the model by the clock edge that follows
    if (!rst) begin
      m_ok = 1'b1; m_last_adc = '0; m_in_win = 0; m_ovf = 0; m_hi = 0; m_pend = 0;
      m_win.delete(); m_fifo.delete(); m_ev = 0; m_drop = 0; m_rej = 0;
    end else begin
      s14 = m_last_adc[AW-1:0];
      s   = s14;
      if (m_fifo.size() != 0 && tready) void'(m_fifo.pop_front());
      if (m_pend) begin
        if (m_fifo.size() < DEPTH) begin
          m_fifo.push_back(m_pend_word);
          m_ev = m_ev + 32'd1;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
      m_pend = 0;
      if (!m_in_win) begin
        if (enable && vgl) begin
          m_in_win = 1; m_ovf = 0; m_win.delete(); m_win.push_back(s); m_hi = vgh;
        end
      end else if (vgl) begin
        if (!m_ovf) begin
          if (m_win.size() == MAX_LEN) begin
            m_ovf = 1;
            if (m_rej < 65535) m_rej++;
          end else begin
            m_win.push_back(s);
            m_hi = m_hi | vgh;
          end
        end
      end else begin
        m_in_win = 0;
        if (!m_ovf) begin
          len = m_win.size();
          pk  = m_win[0];
          foreach (m_win[i]) if (m_win[i] > pk) pk = m_win[i];
          if (len >= MIN_LEN && len <= MAX_LEN && !m_hi) begin
            m_pend = 1;
            m_pend_word = ev_word(len, pk);
          end else if (m_rej < 65535) begin
            m_rej++;
          end
        end
      end
      m_last_adc = adc_dat_a;
    end
  end

  // ---------------- stimulus ----------------
  // One ADC cycle: new sample now, its threshold flags appear one cycle later.
  task automatic cyc(input int s, input bit gl, input bit gh);
    logic [31:0] t;
    t = s;
    adc_dat_a = {18'h15A5A, t[13:0]};
    vgl = pgl; vgh = pgh;
    pgl = gl;  pgh = gh;
    @(posedge adc_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 1'b0, 1'b0);
  endtask

  task automatic pulse3(input int a, input int b, input int c);
    cyc(a, 1'b1, 1'b0);
    cyc(b, 1'b1, 1'b0);
    cyc(c, 1'b1, 1'b0);
  endtask

  initial begin
    int nb;
    rst = 1'b0;
    idle(3);
    check32("reset_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check32("reset_tdata", m_axis_tdata, 32'd0);
    check32("reset_event_cnt", event_cnt, 32'd0);
    rst = 1'b1; enable = 1'b1; tready = 1'b1;
    idle(2);

    // pulse: 100,300,800,500,200 -> len 5, peak 800
    cyc(100, 1, 0); cyc(300, 1, 0); cyc(800, 1, 0); cyc(500, 1, 0); cyc(200, 1, 0);
    cyc(0, 0, 0);              // last vgl=1 reaches the DUT
    cyc(0, 0, 0);              // first vgl=0 cycle
    check32("latency_tvalid_early", {31'd0, m_axis_tvalid}, 32'd0);
    cyc(0, 0, 0);              // push cycle
    check32("latency_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    check32("pulse_tdata", m_axis_tdata, 32'h0001_4320);
    check32("pulse_event_cnt", event_cnt, 32'd1);
    idle(4);
    check32("pulse_beats", 32'(beats.size()), 32'd1);

    // negative peak, enable dropped mid-window
    cyc(-50, 1, 0); cyc(-10, 1, 0);
    enable = 1'b0;
    cyc(-30, 1, 0);
    idle(6);
    enable = 1'b1;
    check32("negpeak_beats", 32'(beats.size()), 32'd2);
    check32("negpeak_word", beats[1], 32'h0000_FFF6);

    // rejections
    cyc(500, 1, 0); idle(6);
    check32("rej_short", {16'd0, reject_cnt}, 32'd1);
    cyc(100, 1, 0); cyc(200, 1, 1); cyc(150, 1, 0); idle(6);
    check32("rej_vgh", {16'd0, reject_cnt}, 32'd2);
    repeat (1025) cyc(10, 1, 0);
    check32("rej_long_before", {16'd0, reject_cnt}, 32'd2);
    cyc(10, 1, 0);
    check32("rej_long_at_1025", {16'd0, reject_cnt}, 32'd3);
    repeat (74) cyc(10, 1, 0);
    idle(6);
    check32("rej_long_once", {16'd0, reject_cnt}, 32'd3);
    check32("rej_no_event", event_cnt, 32'd2);

    // FIFO full: 6 pulses with tready low
    tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse3(1, 1000 + i * 10, 5);
      idle(4);
    end
    check32("full_event_cnt", event_cnt, 32'd6);
    check32("full_drop_cnt", {16'd0, drop_cnt}, 32'd2);
    check32("full_head", m_axis_tdata, 32'h0000_C3E8);
    tready = 1'b1;
    idle(8);
    check32("full_beats", 32'(beats.size()), 32'd6);
    for (int i = 0; i < 4; i++) check32("full_order", beats[2 + i], ev_word(3, 1000 + i * 10));

    // simultaneous push and pop on a full FIFO
    tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse3(1, 2000 + i, 5);
      idle(4);
    end
    pulse3(1, 2100, 5);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    tready = 1'b1;
    cyc(0, 0, 0);              // push cycle with a pop
    tready = 1'b0;
    check32("simul_drop", {16'd0, drop_cnt}, 32'd2);
    check32("simul_event", event_cnt, 32'd11);
    check32("simul_head", m_axis_tdata, ev_word(3, 2001));
    tready = 1'b1;
    idle(8);
    nb = beats.size();
    check32("simul_beats", 32'(nb), 32'd11);
    check32("simul_last", beats[nb - 1], ev_word(3, 2100));

    // mid-window reset with a pending FIFO entry
    tready = 1'b0;
    pulse3(1, 700, 5); idle(4);
    cyc(100, 1, 0); cyc(400, 1, 0); cyc(300, 1, 0);
    rst = 1'b0;
    cyc(0, 0, 0); cyc(0, 0, 0);
    check32("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check32("rst_tdata", m_axis_tdata, 32'd0);
    rst = 1'b1; tready = 1'b1;
    idle(6);
    check32("rst_event_cnt", event_cnt, 32'd0);
    check32("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check32("rst_reject_cnt", {16'd0, reject_cnt}, 32'd0);
    check32("rst_no_beat", 32'(beats.size()), 32'(nb));
    pulse3(5, 600, 7); idle(6);
    check32("after_rst_event", event_cnt, 32'd1);
    check32("after_rst_word", beats[beats.size() - 1], ev_word(3, 600));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
